sat_decision_unit: RTL and testbench
====================================

# sat_decision_unit

Parametrised decision engine for the hardware SAT/BCP datapath. Holds the free-variable bitmap, picks the lowest-index free variable through a priority encoder, and records each decision on an internal decision stack with per-variable decision levels. Adds what the 8-variable, single-shot engine lacks: implication recording from BCP, and chronological backtracking with polarity flip, level-based unassignment and UNSAT detection. Sits between the BCP unit (implications, conflicts) and the top-level solver controller.

## Interface
- VAR_NUM, 8: number of variables; must be ≥ 2.
- DEPTH, VAR_NUM: decision-stack entries.
- DEFAULT_POL, 1'b1: value given to a fresh decision.
- IDX_W, $clog2(VAR_NUM): variable index width (derived).
- LVL_W, $clog2(DEPTH+1): decision-level width (derived).

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-low.
- decide_req  in  1  request a new decision; sampled only in IDLE.
- backtrack_req  in  1  conflict reported; sampled only in IDLE; wins over decide_req.
- imply_valid  in  1  BCP implication strobe; sampled only in IDLE.
- imply_idx  in  IDX_W  implied variable index.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse ending a decide or backtrack.
- res_code  out  2  valid with done: 00 decision, 01 flipped, 10 all assigned (SAT), 11 UNSAT.
- var_idx  out  IDX_W  variable decided or flipped.
- var_val  out  1  value assigned to var_idx.
- level  out  LVL_W  current decision level (= stack pointer).
- overflow  out  1  sticky; set when a decision finds a free variable but the stack is full.

## Operation
- State: free[VAR_NUM] (1 = unassigned); lvl[v] (LVL_W each); stack of DEPTH entries {idx, val, flipped}; sp in 0..DEPTH.
- Reset: free all 1, lvl all 0, sp 0, stack cleared, state IDLE; busy, done, res_code, var_idx, var_val, level and overflow all 0.
- FSM states: IDLE, PICK, BT.
- IDLE: backtrack_req → BT; else decide_req → PICK; else imply_valid → if free[imply_idx] then free[imply_idx]←0 and lvl[imply_idx]←sp, otherwise ignored. Stay in IDLE. An implication sampled together with a request is dropped.
- PICK, one cycle, then IDLE:
  - The priority encoder scans free; the lowest set index wins.
  - No free bit: done, res_code 10; var_idx and var_val hold their previous values.
  - sp==DEPTH: overflow←1, done, res_code 10; no state change.
  - Otherwise: push {idx, DEFAULT_POL, 0}, free[idx]←0, lvl[idx]←sp+1, sp←sp+1, var_idx←idx, var_val←DEFAULT_POL, done, res_code 00.
- BT, one step per cycle:
  - sp==0: done, res_code 11, go to IDLE; bitmap untouched.
  - Top entry (sp-1) with flipped=0: free every v with !free[v] and lvl[v]==sp, except the top idx. Set the entry to {idx, ~val, 1}; idx keeps level sp. Drive var_idx←idx, var_val←~val, done, res_code 01, go to IDLE.
  - Top entry with flipped=1: free every v with lvl[v]==sp, including idx. sp←sp-1. Stay in BT.
- Level-0 implications (made at sp==0) are never freed.
- lvl compare and clear is fully parallel: a single cycle regardless of VAR_NUM.

## Timing
- Decide: request sampled at edge E0; PICK occupies E0→E1; outputs and done registered at E1. done is high for the cycle after E1. Latency 2 edges.
- Backtrack: sampled at E0; k flipped pops take k cycles; the terminating step (flip or UNSAT) registers at edge E(k+1). done is high for the following cycle.
- Implication: bitmap and lvl update at the sampling edge; visible to a PICK starting the next cycle.
- busy rises at the edge after acceptance and falls at the edge that raises done.
- Requests arriving while busy are ignored; the controller must hold them or re-issue after done.
- Asynchronous reset mid-PICK or mid-BT aborts immediately. All state returns to reset values; no done pulse is generated.

## Test plan
- Reset, then decide ×3 → var_idx 0, 1, 2; var_val 1; res_code 00; level 1, 2, 3; done 2 edges after each request.
- imply_idx=0 at sp=0, then decide → var_idx 1, level 1. Backtrack ×2 → 01 (var 1 = 0), then 11 UNSAT. Var 0 is still assigned.
- Decide var 0, imply vars 3 and 5 (level 1), backtrack → res_code 01, var_idx 0, var_val 0. Vars 3 and 5 are free again; next decide picks var 1.
- Decide 0, decide 1, backtrack (flip 1), backtrack → pops level 2 in 1 cycle then flips 0. Done arrives 2 edges after acceptance; level 1; var 1 is free.
- Assign all 8 variables by decisions and implications, then decide → res_code 10, level unchanged.
- DEPTH=2, all 8 variables free: decide ×3 → the third sets overflow=1 and res_code 10. Assert reset during a BT walk → all outputs 0, free=8'hFF.

Source files
------------

// File: rtl/sat_decision_unit.sv
// rtl/sat_decision_unit.sv - SAT decision engine: free bitmap, priority pick, decision stack, chronological backtrack
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-low reset
//   decide_req     request a new decision (sampled in IDLE)
//   backtrack_req  conflict reported, wins over decide_req (sampled in IDLE)
//   imply_valid    BCP implication strobe (sampled in IDLE, dropped when a request is present)
//   imply_idx      implied variable index
//   busy           high whenever the engine is not in IDLE
//   done           one-cycle pulse ending a decide or backtrack
//   res_code       00 decision, 01 flipped, 10 all assigned, 11 UNSAT (valid with done)
//   var_idx        variable decided or flipped
//   var_val        value assigned to var_idx
//   level          current decision level (stack pointer)
//   overflow       sticky: a free variable was found while the stack was full

module sat_decision_unit #(
  parameter int   VAR_NUM     = 8,
  parameter int   DEPTH       = VAR_NUM,
  parameter logic DEFAULT_POL = 1'b1,
  localparam int  IDX_W       = $clog2(VAR_NUM),
  localparam int  LVL_W       = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             decide_req,
  input  logic             backtrack_req,
  input  logic             imply_valid,
  input  logic [IDX_W-1:0] imply_idx,
  output logic             busy,
  output logic             done,
  output logic [1:0]       res_code,
  output logic [IDX_W-1:0] var_idx,
  output logic             var_val,
  output logic [LVL_W-1:0] level,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    BT   = 2'd2
  } state_t;

  state_t           state;
  logic [VAR_NUM-1:0] free;
  logic [LVL_W-1:0] lvl [VAR_NUM];
  logic [IDX_W-1:0] stk_idx [DEPTH];
  logic             stk_val [DEPTH];
  logic             stk_flp [DEPTH];
  logic [LVL_W-1:0] sp;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [LVL_W-1:0] top_ptr;
  logic [IDX_W-1:0] top_idx;
  logic             top_val;
  logic             top_flp;

  assign level   = sp;
  assign top_ptr = sp - 1'b1;

  // Lowest free index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = VAR_NUM - 1; i >= 0; i--) begin
      if (free[i]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
  end

  // Stack accesses go through compare loops so the pointer width never has
  // to match the array index width exactly.
  always_comb begin
    top_idx = '0;
    top_val = 1'b0;
    top_flp = 1'b0;
    for (int d = 0; d < DEPTH; d++) begin
      if (LVL_W'(d) == top_ptr) begin
        top_idx = stk_idx[d];
        top_val = stk_val[d];
        top_flp = stk_flp[d];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      free     <= '1;
      sp       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      res_code <= 2'b00;
      var_idx  <= '0;
      var_val  <= 1'b0;
      overflow <= 1'b0;
      for (int v = 0; v < VAR_NUM; v++) begin
        lvl[v] <= '0;
      end
      for (int d = 0; d < DEPTH; d++) begin
        stk_idx[d] <= '0;
        stk_val[d] <= 1'b0;
        stk_flp[d] <= 1'b0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (backtrack_req) begin
            state <= BT;
            busy  <= 1'b1;
          end else if (decide_req) begin
            state <= PICK;
            busy  <= 1'b1;
          end else if (imply_valid) begin
            for (int v = 0; v < VAR_NUM; v++) begin
              if (IDX_W'(v) == imply_idx && free[v]) begin
                free[v] <= 1'b0;
                lvl[v]  <= sp;
              end
            end
          end
        end

        PICK: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (!pick_found) begin
            res_code <= 2'b10;
          end else if (sp == LVL_W'(DEPTH)) begin
            overflow <= 1'b1;
            res_code <= 2'b10;
          end else begin
            for (int d = 0; d < DEPTH; d++) begin
              if (LVL_W'(d) == sp) begin
                stk_idx[d] <= pick_idx;
                stk_val[d] <= DEFAULT_POL;
                stk_flp[d] <= 1'b0;
              end
            end
            for (int v = 0; v < VAR_NUM; v++) begin
              if (IDX_W'(v) == pick_idx) begin
                free[v] <= 1'b0;
                lvl[v]  <= sp + 1'b1;
              end
            end
            sp       <= sp + 1'b1;
            var_idx  <= pick_idx;
            var_val  <= DEFAULT_POL;
            res_code <= 2'b00;
          end
        end

        BT: begin
          if (sp == '0) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            res_code <= 2'b11;
          end else if (!top_flp) begin
            // Undo everything implied at this level but keep the decision
            // variable itself, now carrying the opposite value.
            for (int v = 0; v < VAR_NUM; v++) begin
              if (!free[v] && lvl[v] == sp && IDX_W'(v) != top_idx) begin
                free[v] <= 1'b1;
              end
            end
            for (int d = 0; d < DEPTH; d++) begin
              if (LVL_W'(d) == top_ptr) begin
                stk_val[d] <= ~top_val;
                stk_flp[d] <= 1'b1;
              end
            end
            var_idx  <= top_idx;
            var_val  <= ~top_val;
            res_code <= 2'b01;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            // Both polarities tried: drop the whole level and keep walking.
            for (int v = 0; v < VAR_NUM; v++) begin
              if (lvl[v] == sp) begin
                free[v] <= 1'b1;
              end
            end
            sp <= sp - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sat_decision_unit.sv
// tb/tb_sat_decision_unit.sv - self-checking bench for sat_decision_unit

module tb_sat_decision_unit;

  localparam int VN    = 8;
  localparam int DEP   = 8;
  localparam int IDX_W = 3;
  localparam int LVL_W = 4;

  logic             clock;
  logic             reset;
  logic             decide_req;
  logic             backtrack_req;
  logic             imply_valid;
  logic [IDX_W-1:0] imply_idx;
  logic             busy;
  logic             done;
  logic [1:0]       res_code;
  logic [IDX_W-1:0] var_idx;
  logic             var_val;
  logic [LVL_W-1:0] level;
  logic             overflow;

  logic             d2_decide_req;
  logic             d2_backtrack_req;
  logic             d2_imply_valid;
  logic [IDX_W-1:0] d2_imply_idx;
  logic             d2_busy;
  logic             d2_done;
  logic [1:0]       d2_res_code;
  logic [IDX_W-1:0] d2_var_idx;
  logic             d2_var_val;
  logic [1:0]       d2_level;
  logic             d2_overflow;

  int n_cmp = 0;
  int n_err = 0;

  sat_decision_unit #(.VAR_NUM(VN), .DEPTH(DEP), .DEFAULT_POL(1'b1)) dut (
    .clock(clock), .reset(reset), .decide_req(decide_req), .backtrack_req(backtrack_req),
    .imply_valid(imply_valid), .imply_idx(imply_idx), .busy(busy), .done(done),
    .res_code(res_code), .var_idx(var_idx), .var_val(var_val), .level(level),
    .overflow(overflow)
  );

  sat_decision_unit #(.VAR_NUM(VN), .DEPTH(2), .DEFAULT_POL(1'b1)) dut2 (
    .clock(clock), .reset(reset), .decide_req(d2_decide_req), .backtrack_req(d2_backtrack_req),
    .imply_valid(d2_imply_valid), .imply_idx(d2_imply_idx), .busy(d2_busy), .done(d2_done),
    .res_code(d2_res_code), .var_idx(d2_var_idx), .var_val(d2_var_val), .level(d2_level),
    .overflow(d2_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: per-variable assignment level (-1 = free) and a queue of decisions.
  typedef struct {
    int idx;
    bit val;
    bit flp;
  } ent_t;

  int   mlvl [VN];
  ent_t mstk [$];
  int   m_idx;
  bit   m_val;
  bit   m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VN-1:0] mfree();
    logic [VN-1:0] r;
    for (int v = 0; v < VN; v++) r[v] = (mlvl[v] < 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < VN; v++) mlvl[v] = -1;
    mstk.delete();
    m_idx = 0;
    m_val = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_decide(output int code, output int cyc);
    int pick;
    pick = -1;
    for (int v = VN - 1; v >= 0; v--) if (mlvl[v] < 0) pick = v;
    cyc = 1;
    if (pick < 0) begin
      code = 2;
    end else if (mstk.size() == DEP) begin
      m_ovf = 1'b1;
      code  = 2;
    end else begin
      ent_t e;
      e.idx = pick; e.val = 1'b1; e.flp = 1'b0;
      mstk.push_back(e);
      mlvl[pick] = mstk.size();
      m_idx = pick;
      m_val = 1'b1;
      code  = 0;
    end
  endtask

  task automatic model_bt(output int code, output int cyc);
    int k, sz;
    k = 0;
    while (mstk.size() > 0 && mstk[mstk.size()-1].flp) begin
      sz = mstk.size();
      for (int v = 0; v < VN; v++) if (mlvl[v] == sz) mlvl[v] = -1;
      void'(mstk.pop_back());
      k++;
    end
    cyc = k + 1;
    if (mstk.size() == 0) begin
      code = 3;
    end else begin
      sz = mstk.size();
      for (int v = 0; v < VN; v++)
        if (v != mstk[sz-1].idx && mlvl[v] == sz) mlvl[v] = -1;
      mstk[sz-1].val = ~mstk[sz-1].val;
      mstk[sz-1].flp = 1'b1;
      m_idx = mstk[sz-1].idx;
      m_val = mstk[sz-1].val;
      code  = 1;
    end
  endtask

  task automatic check_result(input string tag, input int code, input int ecyc, input int cyc);
    chk({tag, "_cyc"},   32'(cyc), 32'(ecyc));
    chk({tag, "_done"},  32'(done), 32'd1);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_res"},   32'(res_code), 32'(code));
    chk({tag, "_idx"},   32'(var_idx), 32'(m_idx));
    chk({tag, "_val"},   32'(var_val), 32'(m_val));
    chk({tag, "_lvl"},   32'(level), 32'(mstk.size()));
    chk({tag, "_ovf"},   32'(overflow), 32'(m_ovf));
    chk({tag, "_free"},  32'(dut.free), 32'(mfree()));
    @(posedge clock); #1;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clock); #1;
      cyc++;
    end while (!done && cyc < 40);
  endtask

  // An implication raised alongside the request must be dropped.
  task automatic do_decide(input string tag, input bit with_imply, input int iv);
    int code, ecyc, cyc;
    model_decide(code, ecyc);
    decide_req  = 1'b1;
    imply_valid = with_imply;
    imply_idx   = IDX_W'(iv);
    @(posedge clock); #1;
    decide_req  = 1'b0;
    imply_valid = 1'b0;
    chk({tag, "_busyhi"}, 32'(busy), 32'd1);
    wait_done(cyc);
    check_result(tag, code, ecyc, cyc);
  endtask

  task automatic do_bt(input string tag);
    int code, ecyc, cyc;
    model_bt(code, ecyc);
    backtrack_req = 1'b1;
    decide_req    = 1'($urandom_range(0, 1));
    @(posedge clock); #1;
    backtrack_req = 1'b0;
    decide_req    = 1'b0;
    chk({tag, "_busyhi"}, 32'(busy), 32'd1);
    wait_done(cyc);
    check_result(tag, code, ecyc, cyc);
  endtask

  task automatic do_imply(input string tag, input int v);
    imply_valid = 1'b1;
    imply_idx   = IDX_W'(v);
    @(posedge clock); #1;
    imply_valid = 1'b0;
    if (mlvl[v] < 0) mlvl[v] = mstk.size();
    chk({tag, "_free"}, 32'(dut.free), 32'(mfree()));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic tb_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    #4;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    int code, ecyc;
    reset = 1'b0;
    decide_req = 1'b0; backtrack_req = 1'b0; imply_valid = 1'b0; imply_idx = '0;
    d2_decide_req = 1'b0; d2_backtrack_req = 1'b0; d2_imply_valid = 1'b0; d2_imply_idx = '0;
    model_reset();
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res",  32'(res_code), 32'd0);
    chk("rst_idx",  32'(var_idx), 32'd0);
    chk("rst_val",  32'(var_val), 32'd0);
    chk("rst_lvl",  32'(level), 32'd0);
    chk("rst_ovf",  32'(overflow), 32'd0);
    chk("rst_free", 32'(dut.free), 32'hFF);
    reset = 1'b1;

    // Three plain decisions.
    for (int i = 0; i < 3; i++) begin
      do_decide("dec3", 1'b0, 0);
      chk("dec3_idx_const", 32'(var_idx), 32'(i));
      chk("dec3_lvl_const", 32'(level), 32'(i + 1));
    end

    // Level-0 implication survives UNSAT.
    tb_reset();
    do_imply("imp0", 0);
    do_decide("imp0_dec", 1'b0, 0);
    chk("imp0_dec_idx", 32'(var_idx), 32'd1);
    do_bt("imp0_bt1");
    chk("imp0_bt1_res", 32'(res_code), 32'd1);
    do_bt("imp0_bt2");
    chk("imp0_bt2_res", 32'(res_code), 32'd3);
    chk("imp0_keep", 32'(dut.free[0]), 32'd0);

    // Implications at level 1 released by the flip.
    tb_reset();
    do_decide("l1_dec", 1'b0, 0);
    do_imply("l1_imp3", 3);
    do_imply("l1_imp5", 5);
    do_bt("l1_bt");
    chk("l1_bt_val", 32'(var_val), 32'd0);
    chk("l1_free35", 32'({dut.free[5], dut.free[3]}), 32'd3);
    do_decide("l1_dec2", 1'b0, 0);
    chk("l1_dec2_idx", 32'(var_idx), 32'd1);

    // Pop a flipped level, then flip the one below.
    tb_reset();
    do_decide("pop_d0", 1'b0, 0);
    do_decide("pop_d1", 1'b0, 0);
    do_bt("pop_bt1");
    do_bt("pop_bt2");
    chk("pop_free1", 32'(dut.free[1]), 32'd1);

    // Everything assigned -> SAT code, level unchanged.
    tb_reset();
    for (int i = 0; i < 3; i++) do_decide("sat_d", 1'b0, 0);
    for (int v = 3; v < VN; v++) do_imply("sat_i", v);
    do_decide("sat", 1'b0, 0);
    chk("sat_res", 32'(res_code), 32'd2);
    chk("sat_lvl", 32'(level), 32'd3);

    // Shallow stack overflows on the third decision.
    tb_reset();
    for (int i = 0; i < 3; i++) begin
      d2_decide_req = 1'b1;
      @(posedge clock); #1;
      d2_decide_req = 1'b0;
      @(posedge clock); #1;
      chk("ovf_done", 32'(d2_done), 32'd1);
      chk("ovf_res",  32'(d2_res_code), (i < 2) ? 32'd0 : 32'd2);
      chk("ovf_flag", 32'(d2_overflow), (i < 2) ? 32'd0 : 32'd1);
      chk("ovf_idx",  32'(d2_var_idx), (i < 2) ? 32'(i) : 32'd1);
      chk("ovf_lvl",  32'(d2_level), (i < 2) ? 32'(i + 1) : 32'd2);
    end

    // Asynchronous reset in the middle of a backtrack walk.
    tb_reset();
    do_decide("ar_d0", 1'b0, 0);
    do_decide("ar_d1", 1'b0, 0);
    do_bt("ar_bt");
    backtrack_req = 1'b1;
    @(posedge clock); #1;
    backtrack_req = 1'b0;
    chk("ar_inbt", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_res",  32'(res_code), 32'd0);
    chk("ar_idx",  32'(var_idx), 32'd0);
    chk("ar_val",  32'(var_val), 32'd0);
    chk("ar_lvl",  32'(level), 32'd0);
    chk("ar_ovf",  32'(overflow), 32'd0);
    chk("ar_free", 32'(dut.free), 32'hFF);
    @(posedge clock); @(posedge clock); #1;
    chk("ar_nodone", 32'(done), 32'd0);
    reset = 1'b1;
    model_reset();

    // Randomised mix against the model.
    tb_reset();
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) begin
        do_decide("rnd_dec", (r == 0), $urandom_range(0, VN - 1));
      end else if (r < 7) begin
        do_imply("rnd_imp", $urandom_range(0, VN - 1));
      end else begin
        do_bt("rnd_bt");
        if (res_code == 2'b11 && $urandom_range(0, 1) == 1) tb_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
